// File: rtl/seg7_hex_capture.sv
// seg7_hex_capture
//   Watches a multiplexed, active-low 7-segment display bus and turns each
//   stable segment pattern back into a hex nibble. It assembles the decoded
//   digits into a multi-digit word and flags frames that contain illegal
//   patterns.
//
// Ports
//   clk          : system clock, all state changes on the rising edge
//   reset        : synchronous, active-high reset
//   SEG[6:0]     : segment lines, active low, SEG[0]=a .. SEG[6]=g
//   DIG_EN       : digit enables, active low, bit k selects digit k
//   NIBBLES      : live decoded value per slot, slot k = NIBBLES[4k+3:4k]
//   SLOT_ERR     : last capture of slot k was an illegal pattern
//   SLOT_BLANK   : last capture of slot k was blank (all segments off)
//   FRAME        : word latched when every slot has been captured once
//   FRAME_ERR    : OR of the slot error flags over the latched frame
//   FRAME_STROBE : one-cycle pulse marking a FRAME/FRAME_ERR update
module seg7_hex_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            SEG,
  input  logic [DIGITS-1:0]     DIG_EN,
  output logic [4*DIGITS-1:0]   NIBBLES,
  output logic [DIGITS-1:0]     SLOT_ERR,
  output logic [DIGITS-1:0]     SLOT_BLANK,
  output logic [4*DIGITS-1:0]   FRAME,
  output logic                  FRAME_ERR,
  output logic                  FRAME_STROBE
);

  localparam int              SMP_W   = DIGITS + 7;
  localparam logic [7:0]      CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]      CNT_CAP = 8'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] EN_ONE = DIGITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // Decode a segment pattern into {legal, blank, nibble}; exact match only.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b1000000: res = {2'b10, 4'h0};
      7'b1111001: res = {2'b10, 4'h1};
      7'b0100100: res = {2'b10, 4'h2};
      7'b0110000: res = {2'b10, 4'h3};
      7'b0011001: res = {2'b10, 4'h4};
      7'b0010010: res = {2'b10, 4'h5};
      7'b0000010: res = {2'b10, 4'h6};
      7'b1111000: res = {2'b10, 4'h7};
      7'b0000000: res = {2'b10, 4'h8};
      7'b0010000: res = {2'b10, 4'h9};
      7'b0001000: res = {2'b10, 4'hA};
      7'b0000011: res = {2'b10, 4'hB};
      7'b1000110: res = {2'b10, 4'hC};
      7'b0100001: res = {2'b10, 4'hD};
      7'b0000110: res = {2'b10, 4'hE};
      7'b0001110: res = {2'b10, 4'hF};
      7'b1111111: res = {2'b01, 4'h0};
      default:    res = {2'b00, 4'h0};
    endcase
    return res;
  endfunction

  state_t                state_r, state_nx_s;
  logic [SMP_W-1:0]      smp_r;
  logic [7:0]            cnt_r, cnt_nx_s;
  logic [4*DIGITS-1:0]   nib_r, nib_nx_s;
  logic [DIGITS-1:0]     err_r, err_nx_s;
  logic [DIGITS-1:0]     blank_r, blank_nx_s;
  logic [DIGITS-1:0]     seen_r, seen_nx_s;
  logic [4*DIGITS-1:0]   frame_r;
  logic                  frame_err_r;
  logic                  strobe_r;

  logic [SMP_W-1:0]      in_s;
  logic                  same_s;
  logic [DIGITS-1:0]     en_low_s;
  logic                  single_s;
  logic                  cap_s;
  logic                  done_s;
  logic [5:0]            dec_s;

  // Input qualification: match against the sample and one-enable-low test.
  always_comb begin
    in_s     = {DIG_EN, SEG};
    same_s   = (in_s == smp_r);
    en_low_s = ~DIG_EN;
    // x & (x-1) clears the lowest set bit; zero result means one bit set.
    single_s = (en_low_s != '0) && ((en_low_s & (en_low_s - EN_ONE)) == '0);
    dec_s    = seg_decode(SEG);
  end

  // Stability counter: restart at 1 on change, otherwise saturate.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (!same_s) begin
      cnt_nx_s = 8'd1;
    end else if (cnt_r < CNT_MAX) begin
      cnt_nx_s = cnt_r + 8'd1;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Next-state logic; any input change falls back to TRACK or IDLE.
  always_comb begin
    state_nx_s = state_r;
    if (!same_s) begin
      state_nx_s = single_s ? ST_TRACK : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = single_s ? ST_TRACK : ST_IDLE;
        ST_TRACK: state_nx_s = cap_s ? ST_HELD : ST_TRACK;
        ST_HELD:  state_nx_s = ST_HELD;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Output logic: capture fires once, on the STABLE_CYCLES-th identical edge.
  always_comb begin
    cap_s = 1'b0;
    case (state_r)
      ST_TRACK: cap_s = same_s && (cnt_r == CNT_CAP);
      ST_IDLE:  cap_s = 1'b0;
      ST_HELD:  cap_s = 1'b0;
      default:  cap_s = 1'b0;
    endcase
  end

  // Per-slot update for the captured digit and the seen-mask.
  always_comb begin
    nib_nx_s   = nib_r;
    err_nx_s   = err_r;
    blank_nx_s = blank_r;
    seen_nx_s  = seen_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (cap_s && en_low_s[k]) begin
        seen_nx_s[k] = 1'b1;
        if (dec_s[5]) begin
          nib_nx_s[4*k +: 4] = dec_s[3:0];
          err_nx_s[k]        = 1'b0;
          blank_nx_s[k]      = 1'b0;
        end else if (dec_s[4]) begin
          nib_nx_s[4*k +: 4] = 4'h0;
          err_nx_s[k]        = 1'b0;
          blank_nx_s[k]      = 1'b1;
        end else begin
          // Illegal pattern keeps the previous nibble.
          err_nx_s[k]        = 1'b1;
          blank_nx_s[k]      = 1'b0;
        end
      end else begin
        seen_nx_s[k] = seen_r[k];
      end
    end
    done_s = cap_s && (seen_nx_s == '1);
  end

  // State, sampler, slot and frame registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      smp_r       <= '0;
      cnt_r       <= 8'd0;
      nib_r       <= '0;
      err_r       <= '0;
      blank_r     <= '0;
      seen_r      <= '0;
      frame_r     <= '0;
      frame_err_r <= 1'b0;
      strobe_r    <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      smp_r    <= in_s;
      cnt_r    <= cnt_nx_s;
      nib_r    <= nib_nx_s;
      err_r    <= err_nx_s;
      blank_r  <= blank_nx_s;
      strobe_r <= done_s;
      if (done_s) begin
        frame_r     <= nib_nx_s;
        frame_err_r <= |err_nx_s;
        seen_r      <= '0;
      end else begin
        frame_r     <= frame_r;
        frame_err_r <= frame_err_r;
        seen_r      <= seen_nx_s;
      end
    end
  end

  assign NIBBLES      = nib_r;
  assign SLOT_ERR     = err_r;
  assign SLOT_BLANK   = blank_r;
  assign FRAME        = frame_r;
  assign FRAME_ERR    = frame_err_r;
  assign FRAME_STROBE = strobe_r;

endmodule

// File: tb/tb_seg7_hex_capture.sv
// tb_seg7_hex_capture
//   Directed bench for seg7_hex_capture (DIGITS=4, STABLE_CYCLES=4).
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_seg7_hex_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  SEG;
  logic [3:0]  DIG_EN;
  logic [15:0] NIBBLES;
  logic [3:0]  SLOT_ERR;
  logic [3:0]  SLOT_BLANK;
  logic [15:0] FRAME;
  logic        FRAME_ERR;
  logic        FRAME_STROBE;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int base;

  seg7_hex_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .SEG          (SEG),
    .DIG_EN       (DIG_EN),
    .NIBBLES      (NIBBLES),
    .SLOT_ERR     (SLOT_ERR),
    .SLOT_BLANK   (SLOT_BLANK),
    .FRAME        (FRAME),
    .FRAME_ERR    (FRAME_ERR),
    .FRAME_STROBE (FRAME_STROBE)
  );

  always #5 clk = ~clk;

  // Count strobe cycles independently of the directed sequence.
  always @(posedge clk) begin
    if (FRAME_STROBE === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input int k, input logic [6:0] seg, input int n);
    logic [3:0] one;
    one    = 4'b0001;
    DIG_EN = ~(one << k);
    SEG    = seg;
    tick(n);
  endtask

  task automatic idle(input int n);
    DIG_EN = 4'b1111;
    tick(n);
  endtask

  initial begin
    reset  = 1'b1;
    SEG    = 7'h55;
    DIG_EN = 4'b0101;
    tick(3);
    check("rst_nibbles", 32'(NIBBLES), 32'h0);
    check("rst_err",     32'(SLOT_ERR), 32'h0);
    check("rst_blank",   32'(SLOT_BLANK), 32'h0);
    check("rst_frame",   32'(FRAME), 32'h0);
    check("rst_ferr",    32'(FRAME_ERR), 32'h0);
    check("rst_strobe",  32'(FRAME_STROBE), 32'h0);

    // No enables low: nothing captured.
    reset  = 1'b0;
    DIG_EN = 4'b1111;
    SEG    = 7'h24;
    base   = strobe_cnt;
    tick(20);
    check("idle_nibbles", 32'(NIBBLES), 32'h0);
    check("idle_strobes", 32'(strobe_cnt - base), 32'h0);

    // Stability threshold.
    hold(0, 7'h24, 3);
    idle(1);
    check("short_hold", 32'(NIBBLES), 32'h0);
    hold(0, 7'h24, 4);
    check("hold4_nib", 32'(NIBBLES), 32'h0002);
    idle(1);
    hold(0, 7'h24, 20);
    check("hold20_nib", 32'(NIBBLES), 32'h0002);
    check("hold20_err", 32'(SLOT_ERR), 32'h0);

    // Full frame 1, A, b, F.
    base = strobe_cnt;
    hold(0, 7'h79, 5);
    hold(1, 7'h08, 5);
    hold(2, 7'h03, 5);
    check("pre_frame_strobe", 32'(strobe_cnt - base), 32'h0);
    hold(3, 7'h0E, 4);
    check("f1_strobe", 32'(FRAME_STROBE), 32'h1);
    check("f1_frame",  32'(FRAME), 32'hFBA1);
    check("f1_ferr",   32'(FRAME_ERR), 32'h0);
    check("f1_nib",    32'(NIBBLES), 32'hFBA1);
    tick(1);
    check("f1_strobe_off", 32'(FRAME_STROBE), 32'h0);
    idle(2);
    check("f1_strobe_cnt", 32'(strobe_cnt - base), 32'h1);

    // Illegal pattern on digit 2.
    hold(0, 7'h30, 5);
    hold(1, 7'h12, 5);
    hold(2, 7'h2A, 5);
    check("ill_err",  32'(SLOT_ERR), 32'h4);
    check("ill_nib2", 32'(NIBBLES[11:8]), 32'hB);
    hold(3, 7'h00, 4);
    check("f2_strobe", 32'(FRAME_STROBE), 32'h1);
    check("f2_frame",  32'(FRAME), 32'h8B53);
    check("f2_ferr",   32'(FRAME_ERR), 32'h1);
    tick(1);

    // Blank pattern on digit 2.
    hold(0, 7'h40, 5);
    hold(1, 7'h40, 5);
    hold(2, 7'h7F, 5);
    check("blk_blank", 32'(SLOT_BLANK), 32'h4);
    check("blk_err",   32'(SLOT_ERR), 32'h0);
    check("blk_nib2",  32'(NIBBLES[11:8]), 32'h0);
    hold(3, 7'h78, 4);
    check("f3_strobe", 32'(FRAME_STROBE), 32'h1);
    check("f3_frame",  32'(FRAME), 32'h7000);
    check("f3_ferr",   32'(FRAME_ERR), 32'h0);
    tick(1);

    // Two enables low, then a glitching segment bus.
    base = strobe_cnt;
    hold(0, 7'h10, 5);
    hold(1, 7'h46, 5);
    DIG_EN = 4'b1100;
    SEG    = 7'h24;
    tick(10);
    check("dual_en_nib", 32'(NIBBLES), 32'h70C9);
    for (int i = 0; i < 6; i++) begin
      DIG_EN = 4'b1011;
      SEG    = (i % 2 == 1) ? 7'h30 : 7'h24;
      tick(2);
    end
    check("glitch_nib", 32'(NIBBLES), 32'h70C9);
    hold(2, 7'h21, 5);
    check("partial_strobes", 32'(strobe_cnt - base), 32'h0);
    hold(3, 7'h06, 4);
    check("f4_strobe", 32'(FRAME_STROBE), 32'h1);
    check("f4_frame",  32'(FRAME), 32'hEDC9);
    tick(1);

    // Reset in the middle of a frame.
    hold(0, 7'h79, 5);
    hold(1, 7'h24, 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_nib",   32'(NIBBLES), 32'h0);
    check("mid_rst_frame", 32'(FRAME), 32'h0);
    check("mid_rst_err",   32'(SLOT_ERR), 32'h0);
    check("mid_rst_blank", 32'(SLOT_BLANK), 32'h0);
    base = strobe_cnt;
    hold(2, 7'h30, 5);
    hold(3, 7'h19, 5);
    tick(2);
    check("mid_rst_strobes", 32'(strobe_cnt - base), 32'h0);
    check("mid_rst_frame2",  32'(FRAME), 32'h0);
    check("mid_rst_nib2",    32'(NIBBLES), 32'h4300);
    hold(0, 7'h79, 5);
    hold(1, 7'h24, 4);
    check("f5_strobe", 32'(FRAME_STROBE), 32'h1);
    check("f5_frame",  32'(FRAME), 32'h4321);
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
